pcihellocore_hexscan: RTL

Multiplexed eight-digit seven-segment scanner sitting directly downstream of the `pcihellocore` hex output port. It consumes the 32-bit `out_port` word and shows it as eight hexadecimal digits on a common-anode display. Each digit is driven in turn from a frame-synchronous shadow copy of the word, so the display never shows a torn value. Includes anti-ghosting blank time, leading-zero suppression, and all-ones blanking, so the port's reset value of 0xFFFFFFFF gives a dark display.

---
 rtl/pcihellocore_hexscan.sv | 112 +++++++++++
 1 files changed

// File: rtl/pcihellocore_hexscan.sv
// Eight-digit multiplexed seven-segment scanner for the pcihellocore hex port.
// It shows a frame-synchronous shadow of data_in, with anti-ghost, leading-zero and all-ones blanking.
module pcihellocore_hexscan #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int LZ_BLANK     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] data_in,
    output logic [6:0]  seg_n,
    output logic        dp_n,
    output logic [7:0]  dig_sel_n,
    output logic        frame_tick
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_MAX   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);

    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [31:0]   shadow;
    logic          slot_end;
    logic          frame_end;
    logic [7:0]    upper_zero;
    logic [3:0]    nibble;
    logic          blank;

    function automatic logic [6:0] decode(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign slot_end  = (cnt == CNT_MAX);
    assign frame_end = slot_end && (idx == 3'd7);
    assign nibble    = shadow[{idx, 2'b00} +: 4];

    // upper_zero[k] is set when every nibble at position k and above is zero.
    always_comb begin
        logic acc;
        acc        = 1'b1;
        upper_zero = '0;
        for (int k = 7; k >= 0; k--) begin
            acc           = acc && (shadow[4*k +: 4] == 4'h0);
            upper_zero[k] = acc;
        end
    end

    always_comb begin
        blank = 1'b0;
        if (shadow == 32'hFFFF_FFFF)
            blank = 1'b1;
        else if ((LZ_BLANK != 0) && (idx != 3'd0) && upper_zero[idx])
            blank = 1'b1;
        else if (cnt < BLANK_LIM)
            blank = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 3'd0;
            shadow     <= 32'hFFFF_FFFF;
            frame_tick <= 1'b0;
        end else begin
            cnt        <= slot_end ? '0 : cnt + 1'b1;
            frame_tick <= frame_end;
            if (slot_end)
                idx <= idx + 3'd1;
            if (frame_end)
                shadow <= data_in;
        end
    end

    // Outputs are registered from the current cnt/idx/shadow, so they trail the scan by one cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dig_sel_n <= 8'hFF;
            seg_n     <= 7'h7F;
            dp_n      <= 1'b1;
        end else begin
            dp_n <= 1'b1;
            if (blank) begin
                dig_sel_n <= 8'hFF;
                seg_n     <= 7'h7F;
            end else begin
                dig_sel_n <= ~(8'h01 << idx);
                seg_n     <= decode(nibble);
            end
        end
    end

endmodule
